// File: rtl/pipe_pkg.sv
// Shared types for the decode/execute pipeline register: ALU opcodes, held-instruction
// layout and the register-match rule used by forwarding, snooping and hazard detection.
package pipe_pkg;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_AND  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_NOR  = 4'b0100,
    ALU_XOR  = 4'b0101,
    ALU_SLL  = 4'b0110,
    ALU_SRA  = 4'b0111,
    ALU_SRL  = 4'b1000,
    ALU_SLT  = 4'b1001,
    ALU_SLTU = 4'b1010,
    ALU_LUI  = 4'b1011,
    ALU_PASS = 4'b1111
  } alu_op_e;

  typedef struct packed {
    logic [3:0]        alu_ctrl;
    logic [REG_W-1:0]  rs_addr;
    logic [REG_W-1:0]  rt_addr;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] imm;
    logic [4:0]        shamt;
    logic              src1_sel;
    logic              src2_sel;
    logic              wr_en;
    logic [REG_W-1:0]  wr_addr;
    logic              mem_read;
  } id_ex_t;

  // Register 0 is hardwired, so a producer targeting it never matches anything.
  function automatic logic reg_hit(input logic en, input logic [REG_W-1:0] prod,
                                   input logic [REG_W-1:0] src);
    return en && (prod == src) && (src != '0);
  endfunction

endpackage

// File: rtl/fwd_mux.sv
// Per-source producer match and priority select: EX/MEM first, then MEM/WB, then held data.
module fwd_mux
  import pipe_pkg::*;
#(
  parameter bit FWD_EN = 1'b1
) (
  input  logic [REG_W-1:0]  src_addr,
  input  logic [DATA_W-1:0] held_data,
  input  logic              mem_en,
  input  logic [REG_W-1:0]  mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              wb_en,
  input  logic [REG_W-1:0]  wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              mem_hit,
  output logic              wb_hit,
  output logic [DATA_W-1:0] fwd_data
);

  // Hits are always reported; they drive hazard detection and snooping even without forwarding.
  always_comb begin
    mem_hit  = reg_hit(mem_en, mem_addr, src_addr);
    wb_hit   = reg_hit(wb_en, wb_addr, src_addr);
    fwd_data = held_data;
    if (FWD_EN && mem_hit) begin
      fwd_data = mem_data;
    end else if (FWD_EN && wb_hit) begin
      fwd_data = wb_data;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding, writeback snooping and load-use bubbles.
// Define ID_EX_FORWARD_EN to enable forwarding; otherwise any pending producer stalls.
module id_ex_stage
  import pipe_pkg::*;
#(
  parameter int DW = DATA_W,
  parameter int RW = REG_W
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [3:0]    id_alu_ctrl,
  input  logic [RW-1:0] id_rs_addr,
  input  logic [RW-1:0] id_rt_addr,
  input  logic [DW-1:0] id_rs_data,
  input  logic [DW-1:0] id_rt_data,
  input  logic [DW-1:0] id_imm,
  input  logic [4:0]    id_shamt,
  input  logic          id_src1_sel,
  input  logic          id_src2_sel,
  input  logic          id_wr_en,
  input  logic [RW-1:0] id_wr_addr,
  input  logic          id_mem_read,
  input  logic          flush,
  input  logic          mem_fwd_en,
  input  logic [RW-1:0] mem_fwd_addr,
  input  logic [DW-1:0] mem_fwd_data,
  input  logic          mem_fwd_is_load,
  input  logic          wb_fwd_en,
  input  logic [RW-1:0] wb_fwd_addr,
  input  logic [DW-1:0] wb_fwd_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [3:0]    alu_ctrl,
  output logic [DW-1:0] src1,
  output logic [DW-1:0] src2,
  output logic [DW-1:0] ex_store_data,
  output logic          ex_wr_en,
  output logic [RW-1:0] ex_wr_addr,
  output logic          ex_mem_read
);

`ifdef ID_EX_FORWARD_EN
  localparam bit FWD_ON = 1'b1;
`else
  localparam bit FWD_ON = 1'b0;
`endif

  logic          full_q, full_d;
  id_ex_t        ex_q, ex_d;
  logic          rs_mem_hit, rs_wb_hit, rt_mem_hit, rt_wb_hit;
  logic [DW-1:0] rs_val, rt_val;
  logic          rs_used, rt_used, is_store;
  logic          mem_blocks, wb_blocks, hazard;
  logic          fire, accept;

  fwd_mux #(.FWD_EN(FWD_ON)) u_fwd_rs (
    .src_addr (ex_q.rs_addr),  .held_data(ex_q.rs_data),
    .mem_en   (mem_fwd_en),    .mem_addr (mem_fwd_addr), .mem_data(mem_fwd_data),
    .wb_en    (wb_fwd_en),     .wb_addr  (wb_fwd_addr),  .wb_data (wb_fwd_data),
    .mem_hit  (rs_mem_hit),    .wb_hit   (rs_wb_hit),    .fwd_data(rs_val)
  );

  fwd_mux #(.FWD_EN(FWD_ON)) u_fwd_rt (
    .src_addr (ex_q.rt_addr),  .held_data(ex_q.rt_data),
    .mem_en   (mem_fwd_en),    .mem_addr (mem_fwd_addr), .mem_data(mem_fwd_data),
    .wb_en    (wb_fwd_en),     .wb_addr  (wb_fwd_addr),  .wb_data (wb_fwd_data),
    .mem_hit  (rt_mem_hit),    .wb_hit   (rt_wb_hit),    .fwd_data(rt_val)
  );

  // Without forwarding, every in-flight producer of a used source must retire first.
  assign mem_blocks = FWD_ON ? mem_fwd_is_load : 1'b1;
  assign wb_blocks  = !FWD_ON;
  assign is_store   = !ex_q.mem_read && !ex_q.wr_en;
  assign rs_used    = !ex_q.src1_sel;
  assign rt_used    = !ex_q.src2_sel || is_store;
  assign hazard     = full_q &&
                      ((rs_used && ((rs_mem_hit && mem_blocks) || (rs_wb_hit && wb_blocks))) ||
                       (rt_used && ((rt_mem_hit && mem_blocks) || (rt_wb_hit && wb_blocks))));

  assign out_valid = full_q && !hazard;
  assign fire      = out_valid && out_ready;
  assign in_ready  = !full_q || fire || flush;
  assign accept    = in_valid && in_ready && !flush;

  always_comb begin
    full_d = full_q;
    ex_d   = ex_q;
    if (flush) begin
      full_d = 1'b0;
    end else if (accept) begin
      full_d        = 1'b1;
      ex_d.alu_ctrl = id_alu_ctrl;
      ex_d.rs_addr  = id_rs_addr;
      ex_d.rt_addr  = id_rt_addr;
      ex_d.rs_data  = id_rs_data;
      ex_d.rt_data  = id_rt_data;
      ex_d.imm      = id_imm;
      ex_d.shamt    = id_shamt;
      ex_d.src1_sel = id_src1_sel;
      ex_d.src2_sel = id_src2_sel;
      ex_d.wr_en    = id_wr_en;
      ex_d.wr_addr  = id_wr_addr;
      ex_d.mem_read = id_mem_read;
    end else begin
      if (fire) begin
        full_d = 1'b0;
      end
      if (full_q && rs_wb_hit) begin
        ex_d.rs_data = wb_fwd_data;
      end
      if (full_q && rt_wb_hit) begin
        ex_d.rt_data = wb_fwd_data;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      full_q <= 1'b0;
      ex_q   <= '0;
    end else begin
      full_q <= full_d;
      ex_q   <= ex_d;
    end
  end

  assign alu_ctrl      = ex_q.alu_ctrl;
  assign src1          = ex_q.src1_sel ? {{(DW-5){1'b0}}, ex_q.shamt} : rs_val;
  assign src2          = ex_q.src2_sel ? ex_q.imm : rt_val;
  assign ex_store_data = rt_val;
  assign ex_wr_en      = ex_q.wr_en;
  assign ex_wr_addr    = ex_q.wr_addr;
  assign ex_mem_read   = ex_q.mem_read;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a one-slot queue model of the stage.
module tb_id_ex_stage;

`ifdef ID_EX_FORWARD_EN
  localparam bit FWD_ON = 1'b1;
`else
  localparam bit FWD_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        in_valid, in_ready;
  logic [3:0]  id_alu_ctrl;
  logic [4:0]  id_rs_addr, id_rt_addr, id_shamt, id_wr_addr;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic        id_src1_sel, id_src2_sel, id_wr_en, id_mem_read;
  logic        flush;
  logic        mem_fwd_en, mem_fwd_is_load, wb_fwd_en;
  logic [4:0]  mem_fwd_addr, wb_fwd_addr;
  logic [31:0] mem_fwd_data, wb_fwd_data;
  logic        out_valid, out_ready;
  logic [3:0]  alu_ctrl;
  logic [31:0] src1, src2, ex_store_data;
  logic        ex_wr_en, ex_mem_read;
  logic [4:0]  ex_wr_addr;

  int total = 0;
  int bad   = 0;

  id_ex_stage #(.DW(32), .RW(5)) dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
    .id_alu_ctrl(id_alu_ctrl), .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm), .id_shamt(id_shamt),
    .id_src1_sel(id_src1_sel), .id_src2_sel(id_src2_sel), .id_wr_en(id_wr_en),
    .id_wr_addr(id_wr_addr), .id_mem_read(id_mem_read), .flush(flush),
    .mem_fwd_en(mem_fwd_en), .mem_fwd_addr(mem_fwd_addr), .mem_fwd_data(mem_fwd_data),
    .mem_fwd_is_load(mem_fwd_is_load), .wb_fwd_en(wb_fwd_en), .wb_fwd_addr(wb_fwd_addr),
    .wb_fwd_data(wb_fwd_data), .out_valid(out_valid), .out_ready(out_ready),
    .alu_ctrl(alu_ctrl), .src1(src1), .src2(src2), .ex_store_data(ex_store_data),
    .ex_wr_en(ex_wr_en), .ex_wr_addr(ex_wr_addr), .ex_mem_read(ex_mem_read)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  ctrl;
    logic [4:0]  rs, rt, sh, wa;
    logic [31:0] rsd, rtd, imm;
    logic        s1, s2, wen, mrd;
  } ins_t;

  // The stage holds at most one instruction; the queue is its occupancy.
  ins_t slot[$];

  function automatic logic prod_hit(input logic en, input logic [4:0] prod, input logic [4:0] r);
    return en && (r != 5'd0) && (prod == r);
  endfunction

  function automatic logic [31:0] model_fwd(input logic [4:0] r, input logic [31:0] held);
    if (FWD_ON && prod_hit(mem_fwd_en, mem_fwd_addr, r)) return mem_fwd_data;
    if (FWD_ON && prod_hit(wb_fwd_en, wb_fwd_addr, r)) return wb_fwd_data;
    return held;
  endfunction

  function automatic logic model_stall(input ins_t i);
    logic rs_used, rt_used, mem_c, wb_c;
    rs_used = !i.s1;
    rt_used = !i.s2 || (!i.mrd && !i.wen);
    mem_c = (FWD_ON ? mem_fwd_is_load : 1'b1) &&
            ((rs_used && prod_hit(mem_fwd_en, mem_fwd_addr, i.rs)) ||
             (rt_used && prod_hit(mem_fwd_en, mem_fwd_addr, i.rt)));
    wb_c  = !FWD_ON &&
            ((rs_used && prod_hit(wb_fwd_en, wb_fwd_addr, i.rs)) ||
             (rt_used && prod_hit(wb_fwd_en, wb_fwd_addr, i.rt)));
    return mem_c || wb_c;
  endfunction

  function automatic logic model_valid();
    if (slot.size() != 1) return 1'b0;
    return !model_stall(slot[0]);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelEdge();
    logic fire;
    ins_t t;
    fire = model_valid() && out_ready;
    if (flush) begin
      slot.delete();
      return;
    end
    if (fire) slot.delete(0);
    if (in_valid && slot.size() == 0) begin
      t.ctrl = id_alu_ctrl; t.rs = id_rs_addr; t.rt = id_rt_addr; t.sh = id_shamt;
      t.wa = id_wr_addr; t.rsd = id_rs_data; t.rtd = id_rt_data; t.imm = id_imm;
      t.s1 = id_src1_sel; t.s2 = id_src2_sel; t.wen = id_wr_en; t.mrd = id_mem_read;
      slot.push_back(t);
    end else if (slot.size() == 1) begin
      t = slot[0];
      if (prod_hit(wb_fwd_en, wb_fwd_addr, t.rs)) t.rsd = wb_fwd_data;
      if (prod_hit(wb_fwd_en, wb_fwd_addr, t.rt)) t.rtd = wb_fwd_data;
      slot[0] = t;
    end
  endtask

  always @(posedge clk or negedge resetn) begin
    if (!resetn) slot.delete();
    else modelEdge();
  end

  task automatic compareCycle();
    logic ev, eir;
    ins_t i;
    ev  = model_valid();
    eir = (slot.size() == 0) || (ev && out_ready) || flush;
    checkOutput("cmp_out_valid", {31'b0, out_valid}, {31'b0, ev});
    checkOutput("cmp_in_ready", {31'b0, in_ready}, {31'b0, eir});
    if (!resetn) begin
      checkOutput("cmp_rst_alu_ctrl", {28'b0, alu_ctrl}, 32'h0);
      checkOutput("cmp_rst_src1", src1, 32'h0);
      checkOutput("cmp_rst_src2", src2, 32'h0);
      checkOutput("cmp_rst_wr_en", {31'b0, ex_wr_en}, 32'h0);
      checkOutput("cmp_rst_mem_read", {31'b0, ex_mem_read}, 32'h0);
    end else if (ev) begin
      i = slot[0];
      checkOutput("cmp_alu_ctrl", {28'b0, alu_ctrl}, {28'b0, i.ctrl});
      checkOutput("cmp_src1", src1, i.s1 ? {27'b0, i.sh} : model_fwd(i.rs, i.rsd));
      checkOutput("cmp_src2", src2, i.s2 ? i.imm : model_fwd(i.rt, i.rtd));
      checkOutput("cmp_store_data", ex_store_data, model_fwd(i.rt, i.rtd));
      checkOutput("cmp_wr_en", {31'b0, ex_wr_en}, {31'b0, i.wen});
      checkOutput("cmp_wr_addr", {27'b0, ex_wr_addr}, {27'b0, i.wa});
      checkOutput("cmp_mem_read", {31'b0, ex_mem_read}, {31'b0, i.mrd});
    end
  endtask

  always @(negedge clk) compareCycle();

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 0; id_alu_ctrl = 0; id_rs_addr = 0; id_rt_addr = 0; id_rs_data = 0;
    id_rt_data = 0; id_imm = 0; id_shamt = 0; id_src1_sel = 0; id_src2_sel = 0;
    id_wr_en = 0; id_wr_addr = 0; id_mem_read = 0; flush = 0;
    mem_fwd_en = 0; mem_fwd_addr = 0; mem_fwd_data = 0; mem_fwd_is_load = 0;
    wb_fwd_en = 0; wb_fwd_addr = 0; wb_fwd_data = 0; out_ready = 1;
  endtask

  task automatic applyStimulus(input logic [3:0] ctrl, input logic [4:0] rs, input logic [4:0] rt,
                               input logic [31:0] rsd, input logic [31:0] rtd,
                               input logic [31:0] imm, input logic [4:0] sh,
                               input logic s1, input logic s2, input logic wen,
                               input logic [4:0] wa, input logic mrd);
    in_valid = 1; id_alu_ctrl = ctrl; id_rs_addr = rs; id_rt_addr = rt; id_rs_data = rsd;
    id_rt_data = rtd; id_imm = imm; id_shamt = sh; id_src1_sel = s1; id_src2_sel = s2;
    id_wr_en = wen; id_wr_addr = wa; id_mem_read = mrd;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    idle();
    // Reset values
    @(negedge clk);
    checkOutput("rst_out_valid", {31'b0, out_valid}, 32'h0);
    checkOutput("rst_in_ready", {31'b0, in_ready}, 32'h1);
    checkOutput("rst_alu_ctrl", {28'b0, alu_ctrl}, 32'h0);
    checkOutput("rst_src1", src1, 32'h0);
    step();
    resetn = 1;

    // Simple ADD, held so forwarding can be probed
    applyStimulus(4'h0, 5'd1, 5'd2, 32'd5, 32'd7, 32'h0, 5'd0, 0, 0, 1, 5'd3, 0);
    out_ready = 0;
    step();
    in_valid = 0;
    @(negedge clk);
    checkOutput("add_out_valid", {31'b0, out_valid}, 32'h1);
    checkOutput("add_src1", src1, 32'd5);
    checkOutput("add_src2", src2, 32'd7);
    checkOutput("add_alu_ctrl", {28'b0, alu_ctrl}, 32'h0);
    step();
    mem_fwd_en = 1; mem_fwd_addr = 5'd1; mem_fwd_data = 32'h100;
    @(negedge clk);
    if (FWD_ON) checkOutput("exmem_fwd_src1", src1, 32'h100);
    else        checkOutput("exmem_nofwd_stall", {31'b0, out_valid}, 32'h0);
    step();
    mem_fwd_addr = 5'd0;
    @(negedge clk);
    checkOutput("exmem_r0_src1", src1, 32'd5);
    checkOutput("exmem_r0_valid", {31'b0, out_valid}, 32'h1);
    step();
    mem_fwd_en = 0; out_ready = 1;
    step();
    @(negedge clk);
    checkOutput("add_drained", {31'b0, out_valid}, 32'h0);

    // Load-use on rt, resolved by writeback
    applyStimulus(4'h1, 5'd4, 5'd6, 32'h10, 32'h20, 32'h0, 5'd0, 0, 0, 1, 5'd7, 0);
    step();
    in_valid = 0;
    mem_fwd_en = 1; mem_fwd_addr = 5'd6; mem_fwd_is_load = 1; mem_fwd_data = 32'h999;
    @(negedge clk);
    checkOutput("ldu_stall", {31'b0, out_valid}, 32'h0);
    step();
    mem_fwd_en = 0; mem_fwd_is_load = 0;
    wb_fwd_en = 1; wb_fwd_addr = 5'd6; wb_fwd_data = 32'hDEAD; out_ready = 0;
    @(negedge clk);
    if (FWD_ON) checkOutput("ldu_wb_fwd_src2", src2, 32'hDEAD);
    else        checkOutput("ldu_wb_nofwd_stall", {31'b0, out_valid}, 32'h0);
    step();
    wb_fwd_en = 0; out_ready = 1;
    @(negedge clk);
    checkOutput("ldu_snoop_valid", {31'b0, out_valid}, 32'h1);
    checkOutput("ldu_snoop_src2", src2, 32'hDEAD);
    checkOutput("ldu_snoop_store", ex_store_data, 32'hDEAD);
    step();

    // Back-pressure then back-to-back replacement
    applyStimulus(4'h2, 5'd8, 5'd9, 32'hA, 32'hB, 32'h0, 5'd0, 0, 0, 1, 5'd1, 0);
    step();
    applyStimulus(4'h3, 5'd10, 5'd11, 32'h1, 32'h2, 32'h0, 5'd0, 0, 0, 1, 5'd2, 0);
    out_ready = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("bp_in_ready", {31'b0, in_ready}, 32'h0);
      checkOutput("bp_src1_stable", src1, 32'hA);
      step();
    end
    out_ready = 1;
    @(negedge clk);
    checkOutput("bp_release_ready", {31'b0, in_ready}, 32'h1);
    step();
    applyStimulus(4'h5, 5'd12, 5'd13, 32'h3, 32'h4, 32'h0, 5'd0, 0, 0, 1, 5'd3, 0);
    @(negedge clk);
    checkOutput("b2b_first_ctrl", {28'b0, alu_ctrl}, 32'h3);
    checkOutput("b2b_first_src1", src1, 32'h1);
    step();
    in_valid = 0;
    @(negedge clk);
    checkOutput("b2b_second_ctrl", {28'b0, alu_ctrl}, 32'h5);
    checkOutput("b2b_second_src1", src1, 32'h3);
    step();

    // Flush with an incoming instruction
    applyStimulus(4'h4, 5'd1, 5'd2, 32'h1, 32'h1, 32'h0, 5'd0, 0, 0, 1, 5'd4, 0);
    step();
    applyStimulus(4'h9, 5'd1, 5'd2, 32'h1, 32'h1, 32'h0, 5'd0, 0, 0, 1, 5'd4, 0);
    flush = 1;
    @(negedge clk);
    checkOutput("flush_in_ready", {31'b0, in_ready}, 32'h1);
    step();
    flush = 0; in_valid = 0;
    @(negedge clk);
    checkOutput("flush_no_valid", {31'b0, out_valid}, 32'h0);

    // Shift-amount operand and non-load EX/MEM producer
    applyStimulus(4'h6, 5'd0, 5'd3, 32'h0, 32'h1, 32'h0, 5'd4, 1, 0, 1, 5'd5, 0);
    out_ready = 0;
    step();
    in_valid = 0;
    @(negedge clk);
    checkOutput("sll_src1", src1, 32'd4);
    checkOutput("sll_src2", src2, 32'd1);
    step();
    mem_fwd_en = 1; mem_fwd_addr = 5'd3; mem_fwd_data = 32'h77;
    @(negedge clk);
    if (FWD_ON) checkOutput("sll_mem_fwd_src2", src2, 32'h77);
    else        checkOutput("sll_mem_stall", {31'b0, out_valid}, 32'h0);
    step();
    mem_fwd_en = 0; wb_fwd_en = 1; wb_fwd_addr = 5'd3; wb_fwd_data = 32'h55;
    @(negedge clk);
    if (FWD_ON) checkOutput("sll_wb_fwd_src2", src2, 32'h55);
    else        checkOutput("sll_wb_stall", {31'b0, out_valid}, 32'h0);
    step();
    wb_fwd_en = 0;
    @(negedge clk);
    checkOutput("sll_snooped_valid", {31'b0, out_valid}, 32'h1);
    checkOutput("sll_snooped_src2", src2, 32'h55);

    // Reset while stalled on a load
    step();
    mem_fwd_en = 1; mem_fwd_addr = 5'd3; mem_fwd_is_load = 1;
    @(negedge clk);
    checkOutput("rst_stall_pre", {31'b0, out_valid}, 32'h0);
    step();
    resetn = 0;
    @(negedge clk);
    checkOutput("rst_stall_in_ready", {31'b0, in_ready}, 32'h1);
    checkOutput("rst_stall_src1", src1, 32'h0);
    step();
    resetn = 1; mem_fwd_en = 0; mem_fwd_is_load = 0; out_ready = 1;
    @(negedge clk);
    checkOutput("rst_no_residue", {31'b0, out_valid}, 32'h0);
    step();

    // Randomized traffic against the model
    for (int c = 0; c < 1500; c++) begin
      in_valid        = ($urandom_range(0, 3) != 0);
      id_alu_ctrl     = 4'($urandom_range(0, 15));
      id_rs_addr      = 5'($urandom_range(0, 3));
      id_rt_addr      = 5'($urandom_range(0, 3));
      id_rs_data      = $urandom;
      id_rt_data      = $urandom;
      id_imm          = $urandom;
      id_shamt        = 5'($urandom_range(0, 31));
      id_src1_sel     = ($urandom_range(0, 3) == 0);
      id_src2_sel     = ($urandom_range(0, 2) == 0);
      id_wr_en        = ($urandom_range(0, 2) != 0);
      id_wr_addr      = 5'($urandom_range(0, 31));
      id_mem_read     = ($urandom_range(0, 3) == 0);
      flush           = ($urandom_range(0, 19) == 0);
      mem_fwd_en      = ($urandom_range(0, 1) == 0);
      mem_fwd_addr    = 5'($urandom_range(0, 3));
      mem_fwd_data    = $urandom;
      mem_fwd_is_load = ($urandom_range(0, 2) == 0);
      wb_fwd_en       = ($urandom_range(0, 1) == 0);
      wb_fwd_addr     = 5'($urandom_range(0, 3));
      wb_fwd_data     = $urandom;
      out_ready       = ($urandom_range(0, 3) != 0);
      resetn          = ($urandom_range(0, 249) != 0);
      step();
    end
    resetn = 1;
    idle();
    step();
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
